// File: rtl/btn_counter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btn_counter_pkg                                                  |
// | Shared state types and frame geometry for btn_counter_ctrl.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package btn_counter_pkg;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } ctrl_state_t;

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_HI      = 3'd1,
    TX_WAIT_HI = 3'd2,
    TX_LO      = 3'd3,
    TX_WAIT_LO = 3'd4
  } tx_state_t;

  localparam int FRAME_BYTES = 2;

endpackage
`default_nettype wire

// File: rtl/btn_counter_ctrl_tick_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tick_gen                                                         |
// | Prescaler: one-cycle tick every DIV enabled cycles, holds when   |
// | disabled, synchronous clear.                                     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;

  always_comb begin
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = (presc_q == LAST) ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = en && (presc_q == LAST);

endmodule
`default_nettype wire

// File: rtl/btn_counter_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btn_counter_ctrl                                                 |
// | Run/stop + direction control of a prescaled 0..CNT_MAX counter;  |
// | every new count is sent to the SPI master as a 2-byte frame.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module btn_counter_ctrl
  import btn_counter_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 10,
  parameter int CNT_MAX = 9999,
  parameter int CNT_W   = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_btn_run,
  input  logic             i_btn_clear,
  input  logic             i_btn_dir,
  input  logic             i_spi_busy,
  input  logic             i_spi_done,
  output logic             o_running,
  output logic             o_dir_down,
  output logic [CNT_W-1:0] o_count,
  output logic             o_spi_start,
  output logic [7:0]       o_spi_tx_data
);

  localparam int               DIV    = CLK_HZ / TICK_HZ;
  localparam int               SNAP_W = 8 * FRAME_BYTES;
  localparam logic [CNT_W-1:0] MAXV   = CNT_W'(CNT_MAX);

  ctrl_state_t      ctrl_q, ctrl_d;
  tx_state_t        tx_q, tx_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pending_q, pending_d;
  logic [7:0]       snap_lo_q, snap_lo_d;
  logic             start_q, start_d;
  logic [7:0]       data_q, data_d;

  logic              w_tick;
  logic [SNAP_W-1:0] w_count_ext;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctrl_q == RUN),
    .clr   (i_btn_clear),
    .tick  (w_tick)
  );

  assign w_count_ext = SNAP_W'(count_q);

  always_comb begin
    ctrl_d = ctrl_q;
    case (ctrl_q)
      STOP:    if (i_btn_run) ctrl_d = RUN;
      RUN:     if (i_btn_run) ctrl_d = STOP;
      default: ctrl_d = STOP;
    endcase

    dir_d = dir_q ^ i_btn_dir;

    // Clear outranks a coincident tick; the tick uses the direction held before any toggle this cycle.
    count_d = count_q;
    if (i_btn_clear) begin
      count_d = '0;
    end else if (w_tick) begin
      if (dir_q) begin
        count_d = (count_q == '0) ? MAXV : count_q - CNT_W'(1);
      end else begin
        count_d = (count_q == MAXV) ? '0 : count_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    tx_d      = tx_q;
    pending_d = pending_q;
    snap_lo_d = snap_lo_q;
    start_d   = 1'b0;
    data_d    = data_q;
    case (tx_q)
      TX_IDLE: begin
        if (pending_q && !i_spi_busy) begin
          snap_lo_d = w_count_ext[7:0];
          data_d    = w_count_ext[SNAP_W-1:SNAP_W-8];
          start_d   = 1'b1;
          pending_d = 1'b0;
          tx_d      = TX_HI;
        end
      end
      TX_HI:      tx_d = TX_WAIT_HI;
      TX_WAIT_HI: if (i_spi_done) tx_d = TX_LO;
      TX_LO: begin
        if (!i_spi_busy) begin
          data_d  = snap_lo_q;
          start_d = 1'b1;
          tx_d    = TX_WAIT_LO;
        end
      end
      TX_WAIT_LO: if (i_spi_done) tx_d = TX_IDLE;
      default:    tx_d = TX_IDLE;
    endcase
    // A change landing on the snapshot cycle must still schedule a follow-up frame.
    if (count_d != count_q) pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= STOP;
      tx_q      <= TX_IDLE;
      dir_q     <= 1'b0;
      count_q   <= '0;
      pending_q <= 1'b1;
      snap_lo_q <= '0;
      start_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      tx_q      <= tx_d;
      dir_q     <= dir_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      snap_lo_q <= snap_lo_d;
      start_q   <= start_d;
      data_q    <= data_d;
    end
  end

  assign o_running     = (ctrl_q == RUN);
  assign o_dir_down    = dir_q;
  assign o_count       = count_q;
  assign o_spi_start   = start_q;
  assign o_spi_tx_data = data_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_counter_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_btn_counter_ctrl                                              |
// | Scoreboarded bench: reference count history vs. SPI frames.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_btn_counter_ctrl;

  localparam int DIV     = 10;
  localparam int CNT_MAX = 9999;
  localparam int CNT_W   = 14;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             btn_run = 1'b0, btn_clear = 1'b0, btn_dir = 1'b0;
  logic             spi_busy_m = 1'b0, spi_done = 1'b0, stall = 1'b0;
  logic             spi_busy;
  logic             running, dir_down, spi_start;
  logic [CNT_W-1:0] count;
  logic [7:0]       tx_data;

  assign spi_busy = spi_busy_m | stall;

  always #5 clk = ~clk;

  btn_counter_ctrl #(
    .CLK_HZ (100), .TICK_HZ (10), .CNT_MAX (CNT_MAX), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .i_btn_run (btn_run), .i_btn_clear (btn_clear), .i_btn_dir (btn_dir),
    .i_spi_busy (spi_busy), .i_spi_done (spi_done),
    .o_running (running), .o_dir_down (dir_down), .o_count (count),
    .o_spi_start (spi_start), .o_spi_tx_data (tx_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: run/dir flags, count in modular arithmetic, history of published values.
  bit m_run = 1'b0, m_dir = 1'b0;
  int m_cnt = 0, m_ph = 0;
  int exp_q[$];

  function automatic int step(input int c, input bit dn);
    return dn ? (c + CNT_MAX) % (CNT_MAX + 1) : (c + 1) % (CNT_MAX + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_dir <= 1'b0; m_cnt <= 0; m_ph <= 0;
      exp_q.delete();
      exp_q.push_back(0);
    end else begin
      m_run <= m_run ^ btn_run;
      m_dir <= m_dir ^ btn_dir;
      if (btn_clear) begin
        m_cnt <= 0; m_ph <= 0;
        if (m_cnt != 0) exp_q.push_back(0);
      end else if (m_run) begin
        if (m_ph == DIV - 1) begin
          m_ph  <= 0;
          m_cnt <= step(m_cnt, m_dir);
          exp_q.push_back(step(m_cnt, m_dir));
        end else begin
          m_ph <= m_ph + 1;
        end
      end
    end
  end

  // SPI master model: busy 4 clocks after a start, then a done pulse.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        spi_busy_m = 1'b0; spi_done = 1'b0; cnt = 0;
      end else begin
        spi_done = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin spi_busy_m = 1'b0; spi_done = 1'b1; end
        end else if (spi_start) begin
          spi_busy_m = 1'b1; cnt = 4;
        end
      end
    end
  end

  logic busy_at_edge = 1'b0;
  always @(posedge clk) busy_at_edge <= spi_busy;

  int byte_idx = 0, hi = 0, last_hi = -1, last_lo = -1, last_frame = -1;
  int nframes = 0, nstarts = 0;

  initial begin
    int val;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        byte_idx = 0;
      end else begin
        check("count", int'(count), m_cnt);
        check("running", int'(running), int'(m_run));
        check("dir_down", int'(dir_down), int'(m_dir));
        if (spi_start) begin
          nstarts++;
          check("start_while_busy", int'(busy_at_edge), 0);
          if (byte_idx == 0) begin
            hi = int'(tx_data); byte_idx = 1;
          end else begin
            val = hi * 256 + int'(tx_data);
            last_hi = hi; last_lo = int'(tx_data); last_frame = val;
            byte_idx = 0; nframes++;
            while (exp_q.size() > 0 && exp_q[0] != val) void'(exp_q.pop_front());
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL frame: got %0d, not a pending count value (model count %0d)", val, m_cnt);
            end else begin
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0: btn_run = 1'b1;
      1: btn_clear = 1'b1;
      default: btn_dir = 1'b1;
    endcase
    @(negedge clk);
    btn_run = 1'b0; btn_clear = 1'b0; btn_dir = 1'b0;
  endtask

  task automatic settle(input string name);
    int i = 0;
    while (i < 3000 && !(exp_q.size() == 0 && byte_idx == 0)) begin
      @(negedge clk); i++;
    end
    if (i >= 3000) begin
      total++; bad++;
      $display("FAIL %s_timeout: got %0d unsent values, expected 0", name, exp_q.size());
    end
    repeat (30) @(negedge clk);
    check({name, "_last_frame"}, last_frame, m_cnt);
  endtask

  task automatic wait_cnt(input int target, input string name);
    int i = 0;
    while (i < 5000 && m_cnt != target) begin
      @(negedge clk); i++;
    end
    if (i >= 5000) begin
      total++; bad++;
      $display("FAIL %s_timeout: got count %0d, expected %0d", name, m_cnt, target);
    end
  endtask

  initial begin
    int n, s, i;
    #600000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, s, i;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    settle("reset");
    check("reset_frames", nframes, 1);
    check("reset_hi", last_hi, 0);
    check("reset_lo", last_lo, 0);
    repeat (50) @(negedge clk);
    check("idle_no_start", nstarts, 2);

    pulse(0);
    repeat (30) @(negedge clk);
    check("run30_count", int'(count), 3);
    pulse(0);
    settle("run30");

    // Down from 0 reaches CNT_MAX, then up from CNT_MAX wraps to 0.
    pulse(1); pulse(2); pulse(0);
    wait_cnt(CNT_MAX, "down_wrap");
    pulse(0);
    settle("down_wrap");
    check("wrap_hi", last_hi, 8'h27);
    check("wrap_lo", last_lo, 8'h0F);
    pulse(2); pulse(0);
    wait_cnt(0, "up_wrap");
    pulse(0);
    settle("up_wrap");

    pulse(0);
    i = 0;
    while (i < 5000 && !(m_cnt == 5 && m_ph == DIV - 1)) begin
      @(negedge clk); i++;
    end
    btn_clear = 1'b1;
    @(negedge clk);
    btn_clear = 1'b0;
    check("clear_at_tick", int'(count), 0);
    pulse(0);
    settle("clear_tick");
    n = nframes;
    pulse(1);
    repeat (40) @(negedge clk);
    check("clear_at_zero_frames", nframes, n);

    pulse(0);
    repeat (15) @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    s = nstarts;
    repeat (25) @(negedge clk);
    pulse(0);
    repeat (23) @(negedge clk);
    check("stall_no_start", nstarts, s);
    n = nframes;
    stall = 1'b0;
    settle("stall");
    check("stall_release_frames", int'(nframes - n >= 1 && nframes - n <= 2), 1);

    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      s = $urandom_range(0, 99);
      btn_run   = (s < 3);
      btn_clear = (s >= 3 && s < 5);
      btn_dir   = (s >= 5 && s < 8);
    end
    @(negedge clk);
    btn_run = 1'b0; btn_clear = 1'b0; btn_dir = 1'b0;
    if (m_run) pulse(0);
    settle("random");

    // Reset first while the high-byte start is on the wire, then inside TX_WAIT_HI.
    for (int k = 0; k < 2; k++) begin
      pulse(0);
      i = 0;
      while (i < 3000) begin
        @(posedge clk); #1;
        if (spi_start && byte_idx == 0) break;
        i++;
      end
      check("saw_hi_start", int'(spi_start), 1);
      if (k == 1) begin
        @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("rst_start_drop", int'(spi_start), 0);
      check("rst_running", int'(running), 0);
      check("rst_count", int'(count), 0);
      repeat (2) @(negedge clk);
      n = nframes;
      rst_n = 1'b1;
      settle("mid_reset");
      check("mid_reset_frames", nframes - n, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
